csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit_if.sv | 32 +++
 rtl/csr_unit.sv | 190 +++++++++++++++++++
 tb/tb_csr_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/csr_unit_if.sv
// Commit-stage bus between the pipeline and the machine-mode CSR unit.
// The pipeline drives io_valid to commit the instruction it presents; io_hasStall cancels it.
interface csr_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic            io_valid;
  logic [31:0]     io_instruction;
  logic [2:0]      io_csr_op;
  logic [XLEN-1:0] io_data_in;
  logic            io_hasException;
  logic [3:0]      io_exc_code;
  logic [XLEN-1:0] io_exc_tval;
  logic            io_hasStall;
  logic [XLEN-1:0] io_in_pc;
  logic            io_timer_irq;
  logic [XLEN-1:0] io_redir_target;
  logic [XLEN-1:0] io_csr_info;
  logic            io_isredir;
  logic            io_illegal;

  modport master (
    output io_valid, io_instruction, io_csr_op, io_data_in, io_hasException,
           io_exc_code, io_exc_tval, io_hasStall, io_in_pc, io_timer_irq,
    input  io_redir_target, io_csr_info, io_isredir, io_illegal
  );

  modport slave (
    input  io_valid, io_instruction, io_csr_op, io_data_in, io_hasException,
           io_exc_code, io_exc_tval, io_hasStall, io_in_pc, io_timer_irq,
    output io_redir_target, io_csr_info, io_isredir, io_illegal
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap entry, MRET, timer interrupt and cycle/instret counters.
// Redirect, old-value and illegal outputs are combinational in the commit cycle.
module csr_unit #(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     HART_ID     = 0,
  parameter logic [XLEN-1:0] MTVEC_RESET = XLEN'(64'h8000_0000)
) (
  input logic       clock,
  input logic       reset,
  csr_unit_if.slave bus
);

  localparam logic [2:0] OP_RW     = 3'd1;
  localparam logic [2:0] OP_RS     = 3'd2;
  localparam logic [2:0] OP_RC     = 3'd3;
  localparam logic [2:0] OP_ECALL  = 3'd4;
  localparam logic [2:0] OP_EBREAK = 3'd5;
  localparam logic [2:0] OP_MRET   = 3'd6;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  logic            mst_mie_q, mst_mie_d;
  logic            mst_mpie_q, mst_mpie_d;
  logic            mie_mtie_q, mie_mtie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;

  logic [11:0]     addr;
  logic [4:0]      rs1;
  logic            unused_instr;
  logic            commit, is_csr, wr_req, ill_cond, illegal;
  logic            irq_take, exc_take, ecall, ebreak, mret, trap;
  logic            csr_impl, csr_we;
  logic [XLEN-1:0] csr_rdata, wdata, trap_cause, trap_tval, trap_base, vec_off;

  assign addr         = bus.io_instruction[31:20];
  assign rs1          = bus.io_instruction[19:15];
  assign unused_instr = ^bus.io_instruction[14:0];

  always_comb begin
    csr_rdata = '0;
    csr_impl  = 1'b1;
    case (addr)
      CSR_MSTATUS:  csr_rdata = XLEN'({2'b11, 3'b000, mst_mpie_q, 3'b000, mst_mie_q, 3'b000});
      CSR_MIE:      csr_rdata = XLEN'({mie_mtie_q, 7'b0});
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
      CSR_MIP:      csr_rdata = XLEN'({bus.io_timer_irq, 7'b0});
      CSR_MCYCLE:   csr_rdata = mcycle_q;
      CSR_MINSTRET: csr_rdata = minstret_q;
      CSR_MHARTID:  csr_rdata = XLEN'(HART_ID);
      default:      csr_impl  = 1'b0;
    endcase
  end

  // RS/RC with rs1 = x0 are pure reads, so they may target read-only CSRs.
  assign commit   = reset & bus.io_valid & ~bus.io_hasStall;
  assign is_csr   = (bus.io_csr_op == OP_RW) || (bus.io_csr_op == OP_RS) || (bus.io_csr_op == OP_RC);
  assign wr_req   = (bus.io_csr_op == OP_RW) || (rs1 != 5'd0);
  assign ill_cond = is_csr && (!csr_impl || (wr_req && (addr[11:10] == 2'b11)));
  assign illegal  = commit & ill_cond;

  assign irq_take = commit & mst_mie_q & mie_mtie_q & bus.io_timer_irq;
  assign exc_take = commit & bus.io_hasException;
  assign ecall    = commit & (bus.io_csr_op == OP_ECALL);
  assign ebreak   = commit & (bus.io_csr_op == OP_EBREAK);
  assign mret     = commit & (bus.io_csr_op == OP_MRET);
  assign trap     = irq_take | exc_take | illegal | ecall | ebreak;
  assign csr_we   = commit & is_csr & wr_req & ~ill_cond & ~trap;

  always_comb begin
    trap_cause = '0;
    trap_tval  = '0;
    if (irq_take) begin
      trap_cause = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
    end else if (exc_take) begin
      trap_cause = XLEN'(bus.io_exc_code);
      trap_tval  = bus.io_exc_tval;
    end else if (illegal) begin
      trap_cause = XLEN'(4'd2);
      trap_tval  = XLEN'(bus.io_instruction);
    end else if (ecall) begin
      trap_cause = XLEN'(4'd11);
    end else begin
      trap_cause = XLEN'(4'd3);
      trap_tval  = bus.io_in_pc;
    end
  end

  always_comb begin
    case (bus.io_csr_op)
      OP_RS:   wdata = csr_rdata | bus.io_data_in;
      OP_RC:   wdata = csr_rdata & ~bus.io_data_in;
      default: wdata = bus.io_data_in;
    endcase
  end

  // Vectored mode only offsets interrupts; the sole interrupt source is MTI (code 7).
  assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign vec_off   = (irq_take && (mtvec_q[1:0] == 2'b01)) ? XLEN'(7 * 4) : '0;

  assign bus.io_isredir      = trap | mret;
  assign bus.io_redir_target = trap ? (trap_base + vec_off) : (mret ? mepc_q : '0);
  assign bus.io_illegal      = illegal;
  assign bus.io_csr_info     = (reset && is_csr && !ill_cond) ? csr_rdata : '0;

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_mtie_d = mie_mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + XLEN'(1);
    minstret_d = minstret_q + XLEN'(commit & ~trap);
    if (trap) begin
      mepc_d     = {bus.io_in_pc[XLEN-1:2], 2'b00};
      mcause_d   = trap_cause;
      mtval_d    = trap_tval;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (addr)
        CSR_MSTATUS: begin
          mst_mie_d  = wdata[3];
          mst_mpie_d = wdata[7];
        end
        CSR_MIE:      mie_mtie_d = wdata[7];
        CSR_MTVEC:    mtvec_d    = {wdata[XLEN-1:2], wdata[1] ? 2'b00 : wdata[1:0]};
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = {wdata[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wdata;
        CSR_MTVAL:    mtval_d    = wdata;
        CSR_MCYCLE:   mcycle_d   = wdata;
        CSR_MINSTRET: minstret_d = wdata;
        default:      mtvec_d    = mtvec_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_mtie_q <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_mtie_q <= mie_mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed and randomized checks of csr_unit against a behavioural machine-mode CSR model.
module tb_csr_unit;
  localparam int unsigned XLEN = 64;
  localparam int unsigned HART = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  csr_unit_if #(.XLEN(XLEN)) bus ();
  csr_unit #(.XLEN(XLEN), .HART_ID(HART), .MTVEC_RESET(64'h8000_0000)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_info, obs_target;
  logic        obs_redir, obs_ill;

  // Behavioural model state.
  logic        m_mie, m_mpie, m_mtie;
  logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle, m_minstret;

  logic [11:0] pool [14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                             12'h344, 12'hB00, 12'hB02, 12'hF14, 12'hF11, 12'h345, 12'h7C0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0; m_mtie = 1'b0;
    m_mtvec = 64'h8000_0000; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_mcycle = 0; m_minstret = 0;
  endtask

  function automatic logic model_read(input logic [11:0] a, input logic irq, output logic [63:0] v);
    v = 64'd0;
    model_read = 1'b1;
    case (a)
      12'h300: v = 64'h1800 + (m_mpie ? 64'h80 : 64'h0) + (m_mie ? 64'h8 : 64'h0);
      12'h304: v = m_mtie ? 64'h80 : 64'h0;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = irq ? 64'h80 : 64'h0;
      12'hB00: v = m_mcycle;
      12'hB02: v = m_minstret;
      12'hF14: v = 64'(HART);
      default: model_read = 1'b0;
    endcase
  endfunction

  task automatic step(input logic v, input logic [2:0] op, input logic [11:0] a, input logic [4:0] rs1,
                      input logic [63:0] d, input logic stall, input logic irq, input logic exc,
                      input logic [3:0] code, input logic [63:0] tval, input logic [63:0] pc);
    logic [31:0] instr;
    logic        commit, is_csr, wr, impl, bad, trap, mret, is_int;
    logic [63:0] old, e_target, e_info, cause, mtv, nv, base;
    instr = {a, rs1, 3'd1, 5'd0, 7'h73};
    bus.io_valid = v; bus.io_instruction = instr; bus.io_csr_op = op; bus.io_data_in = d;
    bus.io_hasException = exc; bus.io_exc_code = code; bus.io_exc_tval = tval;
    bus.io_hasStall = stall; bus.io_in_pc = pc; bus.io_timer_irq = irq;
    #2;
    commit = v && !stall;
    is_csr = (op >= 3'd1) && (op <= 3'd3);
    wr     = (op == 3'd1) || (rs1 != 5'd0);
    impl   = model_read(a, irq, old);
    bad    = is_csr && (!impl || (wr && a >= 12'hC00));
    trap = 0; mret = 0; is_int = 0; cause = 0; mtv = 0;
    if (commit) begin
      if (m_mie && m_mtie && irq) begin trap = 1; is_int = 1; cause = (64'd1 << 63) + 64'd7; end
      else if (exc)       begin trap = 1; cause = 64'(code); mtv = tval; end
      else if (bad)       begin trap = 1; cause = 64'd2; mtv = 64'(instr); end
      else if (op == 3'd4) begin trap = 1; cause = 64'd11; end
      else if (op == 3'd5) begin trap = 1; cause = 64'd3; mtv = pc; end
      else if (op == 3'd6) mret = 1;
    end
    base = m_mtvec - (m_mtvec % 4);
    if (trap)      e_target = base + ((is_int && (m_mtvec % 4 == 1)) ? 64'd28 : 64'd0);
    else if (mret) e_target = m_mepc;
    else           e_target = 0;
    e_info = (is_csr && !bad) ? old : 64'd0;
    exp_q.push_back(e_info);
    obs_info = bus.io_csr_info; obs_target = bus.io_redir_target;
    obs_redir = bus.io_isredir; obs_ill = bus.io_illegal;
    check("isredir", 64'(obs_redir), 64'(trap || mret));
    check("redir_target", obs_target, e_target);
    check("illegal", 64'(obs_ill), 64'(commit && bad));
    check("csr_info", obs_info, exp_q.pop_front());
    @(posedge clock);
    m_mcycle = m_mcycle + 1;
    if (commit && !trap) m_minstret = m_minstret + 1;
    if (trap) begin
      m_mepc = pc - (pc % 4); m_mcause = cause; m_mtval = mtv; m_mpie = m_mie; m_mie = 0;
    end else if (mret) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (commit && is_csr && wr && !bad) begin
      nv = (op == 3'd1) ? d : (op == 3'd2) ? (old | d) : (old & ~d);
      case (a)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mtie = nv[7];
        12'h305: m_mtvec = (nv % 4 >= 2) ? nv - (nv % 4) : nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv - (nv % 4);
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: m_mcycle = nv;
        12'hB02: m_minstret = nv;
        default: ;
      endcase
    end
    @(negedge clock);
  endtask

  task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [4:0] rs1, input logic [63:0] d);
    step(1'b1, op, a, rs1, d, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 64'h1000);
  endtask

  task automatic rd(input logic [11:0] a);
    csr(3'd2, a, 5'd0, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    model_reset();
    bus.io_valid = 1'b1; bus.io_instruction = {12'h305, 5'd1, 3'd1, 5'd0, 7'h73};
    bus.io_csr_op = 3'd1; bus.io_data_in = 64'h55; bus.io_hasException = 1'b0;
    bus.io_exc_code = 4'd0; bus.io_exc_tval = 64'd0; bus.io_hasStall = 1'b0;
    bus.io_in_pc = 64'h100; bus.io_timer_irq = 1'b1;
    #12;
    check("reset_info", bus.io_csr_info, 64'd0);
    check("reset_redir", 64'(bus.io_isredir), 64'd0);
    check("reset_target", bus.io_redir_target, 64'd0);
    check("reset_illegal", 64'(bus.io_illegal), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    rd(12'h305);              check("mtvec_reset", obs_info, 64'h8000_0000);
    rd(12'h300);              check("mstatus_reset", obs_info, 64'h1800);
    rd(12'hF14);              check("mhartid", obs_info, 64'd3);
    csr(3'd1, 12'h340, 5'd1, 64'h1234); check("rw_old", obs_info, 64'd0);
    rd(12'h340);              check("rs_x0_read", obs_info, 64'h1234);
    rd(12'h340);              check("rs_x0_nowrite", obs_info, 64'h1234);
    csr(3'd3, 12'h340, 5'd2, 64'h34);  check("rc_old", obs_info, 64'h1234);
    rd(12'h340);              check("rc_new", obs_info, 64'h1200);

    csr(3'd1, 12'h305, 5'd1, 64'h8000_0101);
    csr(3'd1, 12'h300, 5'd1, 64'h8);
    csr(3'd1, 12'h304, 5'd1, 64'h80);
    step(1'b1, 3'd0, 12'h0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 4'd0, 64'd0, 64'h100);
    check("irq_redir", 64'(obs_redir), 64'd1);
    check("irq_target", obs_target, 64'h8000_011C);
    rd(12'h341);              check("irq_mepc", obs_info, 64'h100);
    rd(12'h342);              check("irq_mcause", obs_info, 64'h8000_0000_0000_0007);
    rd(12'h300);              check("irq_mstatus", obs_info, 64'h1880);

    csr(3'd1, 12'h305, 5'd1, 64'h8000_0000);
    csr(3'd2, 12'h300, 5'd1, 64'h8);
    step(1'b1, 3'd4, 12'h0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 64'h200);
    check("ecall_target", obs_target, 64'h8000_0000);
    rd(12'h342);              check("ecall_cause", obs_info, 64'd11);
    rd(12'h300);              check("ecall_mstatus", obs_info, 64'h1880);
    step(1'b1, 3'd6, 12'h0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 64'h300);
    check("mret_target", obs_target, 64'h200);
    rd(12'h300);              check("mret_mstatus", obs_info, 64'h1888);

    csr(3'd1, 12'hF14, 5'd1, 64'h5);
    check("ro_illegal", 64'(obs_ill), 64'd1);
    check("ro_target", obs_target, 64'h8000_0000);
    rd(12'h342);              check("ro_cause", obs_info, 64'd2);
    rd(12'h343);              check("ro_mtval", obs_info, 64'hF140_9073);
    rd(12'hF14);              check("ro_hartid", obs_info, 64'd3);
    step(1'b1, 3'd1, 12'hF14, 5'd1, 64'h5, 1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 64'h1000);
    check("stall_illegal", 64'(obs_ill), 64'd0);
    check("stall_redir", 64'(obs_redir), 64'd0);
    rd(12'h342);              check("stall_cause", obs_info, 64'd2);

    csr(3'd1, 12'hB00, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00);              check("mcycle_ones", obs_info, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00);              check("mcycle_wrap", obs_info, 64'd0);
    step(1'b1, 3'd4, 12'h0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 4'd5, 64'h55, 64'h300);
    rd(12'h342);              check("exc_over_ecall", obs_info, 64'd5);
    rd(12'h343);              check("exc_tval", obs_info, 64'h55);
    step(1'b1, 3'd5, 12'h0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 64'h400);
    rd(12'h343);              check("ebreak_tval", obs_info, 64'h400);
    csr(3'd1, 12'h305, 5'd1, 64'h8000_0003);
    rd(12'h305);              check("mtvec_mode3", obs_info, 64'h8000_0000);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 5) != 0), 3'($urandom_range(0, 7)), pool[$urandom_range(0, 13)],
           ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           {$urandom, $urandom}, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), {$urandom, $urandom},
           {32'd0, $urandom});
    end

    csr(3'd1, 12'h340, 5'd1, 64'hABC);
    bus.io_valid = 1'b1; bus.io_instruction = {12'h305, 5'd1, 3'd1, 5'd0, 7'h73};
    bus.io_csr_op = 3'd1; bus.io_hasStall = 1'b0; bus.io_hasException = 1'b0;
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_info", bus.io_csr_info, 64'd0);
    check("async_reset_redir", 64'(bus.io_isredir), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    rd(12'h340);              check("async_mscratch", obs_info, 64'd0);
    rd(12'h305);              check("async_mtvec", obs_info, 64'h8000_0000);
    rd(12'hB02);              check("async_minstret", obs_info, 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
